// File: rtl/alu_sequencer.sv
// Operand/opcode entry sequencer in front of a combinational ALU.
// Ports: clk, reset (sync, active-high); data_in/op_in from the switches;
// enter/undo single-cycle pulses; alu_a/alu_b/alu_op registered ALU drive;
// alu_result/alu_flags ALU response; result/flags/result_valid capture;
// state_o/disp_value for the display; op_count saturating capture count.
module alu_sequencer #(
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [M-1:0] data_in,
  input  logic [1:0]   op_in,
  input  logic         enter,
  input  logic         undo,
  output logic [M-1:0] alu_a,
  output logic [M-1:0] alu_b,
  output logic [1:0]   alu_op,
  input  logic [M-1:0] alu_result,
  input  logic [4:0]   alu_flags,
  output logic [M-1:0] result,
  output logic [4:0]   flags,
  output logic         result_valid,
  output logic [1:0]   state_o,
  output logic [M-1:0] disp_value,
  output logic [7:0]   op_count
);

  typedef enum logic [1:0] {
    OPA  = 2'b00,
    OPB  = 2'b01,
    OPC  = 2'b10,
    SHOW = 2'b11
  } state_t;

  state_t state;
  // High only during the first cycle spent in SHOW.
  logic   capture_pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= OPA;
      alu_a           <= '0;
      alu_b           <= '0;
      alu_op          <= '0;
      result          <= '0;
      flags           <= '0;
      result_valid    <= 1'b0;
      op_count        <= '0;
      capture_pending <= 1'b0;
    end else begin
      capture_pending <= 1'b0;

      if (capture_pending) begin
        result <= alu_result;
        flags  <= alu_flags;
        if (op_count != 8'hFF) begin
          op_count <= op_count + 8'd1;
        end
      end

      if (undo) begin
        case (state)
          OPB:     state <= OPA;
          OPC:     state <= OPB;
          SHOW: begin
            state        <= OPC;
            result_valid <= 1'b0;
          end
          default: state <= OPA;
        endcase
      end else if (enter) begin
        case (state)
          OPA: begin
            alu_a <= data_in;
            state <= OPB;
          end
          OPB: begin
            alu_b <= data_in;
            state <= OPC;
          end
          OPC: begin
            alu_op          <= op_in;
            state           <= SHOW;
            capture_pending <= 1'b1;
          end
          default: begin
            state        <= OPA;
            result_valid <= 1'b0;
          end
        endcase
      end else if (capture_pending) begin
        result_valid <= 1'b1;
      end
    end
  end

  assign state_o = state;

  always_comb begin
    disp_value = data_in;
    case (state)
      OPC:     disp_value = {{(M-2){1'b0}}, op_in};
      SHOW:    disp_value = result;
      default: disp_value = data_in;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic [1:0] op_in;
  logic       enter;
  logic       undo;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [1:0] alu_op;
  logic [7:0] alu_result;
  logic [4:0] alu_flags;
  logic [7:0] result;
  logic [4:0] flags;
  logic       result_valid;
  logic [1:0] state_o;
  logic [7:0] disp_value;
  logic [7:0] op_count;
  logic       alu_force;

  int vectors;
  int errors;

  alu_sequencer #(.M(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .op_in        (op_in),
    .enter        (enter),
    .undo         (undo),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_flags    (alu_flags),
    .result       (result),
    .flags        (flags),
    .result_valid (result_valid),
    .state_o      (state_o),
    .disp_value   (disp_value),
    .op_count     (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Team ALU: flags = {N,Z,C,V,P}, C is borrow on sub, P is xor of result bits.
  logic [8:0] wide;
  logic       ovf;
  logic [7:0] alu_core;
  always_comb begin
    wide = '0;
    ovf  = 1'b0;
    case (alu_op)
      2'b00: begin
        wide = {1'b0, alu_a} - {1'b0, alu_b};
        ovf  = (alu_a[7] != alu_b[7]) && (wide[7] != alu_a[7]);
      end
      2'b01: begin
        wide = {1'b0, alu_a} + {1'b0, alu_b};
        ovf  = (alu_a[7] == alu_b[7]) && (wide[7] != alu_a[7]);
      end
      2'b10: wide = {1'b0, alu_a | alu_b};
      default: wide = {1'b0, alu_a & alu_b};
    endcase
    alu_core   = wide[7:0];
    alu_result = alu_force ? 8'hEE : alu_core;
    alu_flags  = {alu_result[7], alu_result == 8'h00, wide[8], ovf, ^alu_result};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic enter_val(input logic [7:0] d);
    data_in = d;
    enter   = 1'b1;
    tick();
    enter   = 1'b0;
  endtask

  task automatic enter_op(input logic [1:0] op);
    op_in = op;
    enter = 1'b1;
    tick();
    enter = 1'b0;
  endtask

  task automatic pulse_undo();
    undo = 1'b1;
    tick();
    undo = 1'b0;
  endtask

  initial begin
    vectors   = 0;
    errors    = 0;
    reset     = 1'b1;
    data_in   = '0;
    op_in     = '0;
    enter     = 1'b0;
    undo      = 1'b0;
    alu_force = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    check("rst_state", state_o, 2'b00);
    check("rst_a", alu_a, 8'h00);
    check("rst_b", alu_b, 8'h00);
    check("rst_op", alu_op, 2'b00);
    check("rst_result", result, 8'h00);
    check("rst_flags", flags, 5'b00000);
    check("rst_valid", result_valid, 1'b0);
    check("rst_count", op_count, 8'd0);

    // 5 - 3
    enter_val(8'h05);
    check("sub_stB", state_o, 2'b01);
    check("sub_a", alu_a, 8'h05);
    check("disp_opb", disp_value, 8'h05);
    enter_val(8'h03);
    check("sub_stC", state_o, 2'b10);
    check("sub_b", alu_b, 8'h03);
    op_in = 2'b10;
    #1;
    check("disp_opc", disp_value, 8'h02);
    enter_op(2'b00);
    check("sub_stS", state_o, 2'b11);
    check("sub_valid_early", result_valid, 1'b0);
    tick();
    check("sub_valid", result_valid, 1'b1);
    check("sub_result", result, 8'h02);
    check("sub_flags", flags, 5'b00001);
    check("sub_count", op_count, 8'd1);
    check("disp_show", disp_value, 8'h02);
    alu_force = 1'b1;
    tick();
    tick();
    check("hold_result", result, 8'h02);
    check("hold_count", op_count, 8'd1);
    alu_force = 1'b0;
    enter_val(8'h00);
    check("show_exit_st", state_o, 2'b00);
    check("show_exit_valid", result_valid, 1'b0);

    // 0x80 + 0x80
    enter_val(8'h80);
    enter_val(8'h80);
    enter_op(2'b01);
    tick();
    check("add_result", result, 8'h00);
    check("add_flags", flags, 5'b01110);
    check("add_count", op_count, 8'd2);
    enter_val(8'h00);
    check("add_exit_st", state_o, 2'b00);
    check("add_exit_valid", result_valid, 1'b0);
    check("add_exit_result", result, 8'h00);
    check("add_exit_a", alu_a, 8'h80);

    // undo in OPB
    enter_val(8'h0F);
    pulse_undo();
    check("undo_b_st", state_o, 2'b00);
    check("undo_b_a", alu_a, 8'h0F);
    enter_val(8'h3C);
    check("reenter_a", alu_a, 8'h3C);
    check("reenter_st", state_o, 2'b01);

    // enter and undo together in OPC
    enter_val(8'h11);
    check("opc_st", state_o, 2'b10);
    op_in = 2'b11;
    enter = 1'b1;
    undo  = 1'b1;
    tick();
    enter = 1'b0;
    undo  = 1'b0;
    check("both_st", state_o, 2'b01);
    check("both_op", alu_op, 2'b01);
    enter_val(8'h11);
    enter_op(2'b11);
    tick();
    check("and_result", result, 8'h10);
    check("and_flags", flags, 5'b00001);
    check("and_count", op_count, 8'd3);
    pulse_undo();
    check("undo_s_st", state_o, 2'b10);
    check("undo_s_valid", result_valid, 1'b0);
    check("undo_s_result", result, 8'h10);
    pulse_undo();
    pulse_undo();
    pulse_undo();
    check("undo_a_st", state_o, 2'b00);
    check("undo_keep_a", alu_a, 8'h3C);
    check("undo_keep_b", alu_b, 8'h11);
    check("undo_keep_op", alu_op, 2'b11);

    // enter held high advances one state per cycle
    data_in = 8'h22;
    op_in   = 2'b10;
    enter   = 1'b1;
    tick();
    check("held_st1", state_o, 2'b01);
    tick();
    check("held_st2", state_o, 2'b10);
    tick();
    check("held_st3", state_o, 2'b11);
    enter = 1'b0;
    tick();
    check("held_result", result, 8'h22);
    check("held_flags", flags, 5'b00000);
    check("held_valid", result_valid, 1'b1);
    check("held_count", op_count, 8'd4);
    enter_val(8'h00);

    // reset mid-sequence in OPC
    enter_val(8'hAA);
    enter_val(8'h55);
    reset = 1'b1;
    enter = 1'b1;
    tick();
    reset = 1'b0;
    enter = 1'b0;
    check("rst_opc_st", state_o, 2'b00);
    check("rst_opc_a", alu_a, 8'h00);
    check("rst_opc_b", alu_b, 8'h00);
    check("rst_opc_valid", result_valid, 1'b0);
    check("rst_opc_count", op_count, 8'd0);

    // reset on the pending capture edge
    enter_val(8'h01);
    enter_val(8'h01);
    enter_op(2'b01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("rst_show_result", result, 8'h00);
    check("rst_show_valid", result_valid, 1'b0);
    check("rst_show_count", op_count, 8'd0);

    // saturation
    for (int unsigned i = 0; i < 260; i++) begin
      enter_val(8'h01);
      enter_val(8'h02);
      enter_op(2'b01);
      tick();
      enter_val(8'h00);
      if (i == 254) check("sat_255", op_count, 8'd255);
    end
    check("sat_hold", op_count, 8'd255);
    check("sat_result", result, 8'h03);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
